reorder_buffer: RTL

//  In-order retirement queue of the Tomasulo core. Allocates ROB tags to decoded instructions,

---
 rtl/reorder_buffer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue of the Tomasulo core.
//   Allocates ROB tags (slot index + 1, tag 0 = NULL) to decoded instructions, captures
//   CDB results, retires at most one entry per cycle onto the registered commit bus, and
//   on a mispredicted branch emits a one-cycle rollback pulse with the redirect PC.
//   Completed-but-uncommitted values are exposed to dispatch through the Qj/Qk query ports.
// Ports:
//   clk, rst (async, active-high)
//   dec_*_in / dec_next_tag_out / dec_full_out      : dispatch allocation
//   dec_Qj/Qk_in, dec_Qj/Qk_ready_out, dec_Vj/Vk_out: operand queries (combinational)
//   cdb_*_in                                        : result broadcast
//   rob_commit_*_out                                : registered writeback pulse
//   rob_rollback_out, rob_redirect_pc_out           : registered flush pulse + fetch target
// Configuration:
//   ROB_QUERY_FWD_EN defined  -> queries also match the CDB broadcast of the same cycle.
//   ROB_QUERY_FWD_EN undefined-> queries see latched entry state only.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid_in,
  input  logic [4:0]           dec_rd_in,
  input  logic                 dec_has_rd_in,
  input  logic                 dec_is_branch_in,
  input  logic                 dec_pred_taken_in,
  input  logic [31:0]          dec_alt_pc_in,
  input  logic [TAG_WIDTH-1:0] dec_Qj_in,
  input  logic [TAG_WIDTH-1:0] dec_Qk_in,
  output logic [TAG_WIDTH-1:0] dec_next_tag_out,
  output logic                 dec_full_out,
  output logic                 dec_Qj_ready_out,
  output logic                 dec_Qk_ready_out,
  output logic [31:0]          dec_Vj_out,
  output logic [31:0]          dec_Vk_out,
  input  logic                 cdb_valid_in,
  input  logic [TAG_WIDTH-1:0] cdb_tag_in,
  input  logic [31:0]          cdb_data_in,
  input  logic                 cdb_taken_in,
  output logic                 rob_commit_signal_out,
  output logic [TAG_WIDTH-1:0] rob_commit_tag_out,
  output logic [31:0]          rob_commit_data_out,
  output logic [4:0]           rob_commit_target_out,
  output logic                 rob_rollback_out,
  output logic [31:0]          rob_redirect_pc_out
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE  = TAG_WIDTH'(1);
  localparam logic [TAG_WIDTH-1:0] TAG_NULL = TAG_WIDTH'(0);
  localparam logic [TAG_WIDTH-1:0] MAX_TAG  = TAG_WIDTH'(ROB_SIZE);

  // Tags above ROB_SIZE name no slot and are treated like NULL.
  function automatic logic tag_valid(input logic [TAG_WIDTH-1:0] t);
    return (t != TAG_NULL) && (t <= MAX_TAG);
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_WIDTH-1:0] t);
    logic [TAG_WIDTH-1:0] m;
    m = t - TAG_ONE;
    return m[IDX_W-1:0];
  endfunction

  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d, has_rd_q, has_rd_d;
  logic [ROB_SIZE-1:0] is_branch_q, is_branch_d, pred_taken_q, pred_taken_d, taken_q, taken_d;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [4:0]          rd_d     [ROB_SIZE];
  logic [31:0]         data_q   [ROB_SIZE];
  logic [31:0]         data_d   [ROB_SIZE];
  logic [31:0]         alt_pc_q [ROB_SIZE];
  logic [31:0]         alt_pc_d [ROB_SIZE];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                 commit_signal_q, commit_signal_d;
  logic [TAG_WIDTH-1:0] commit_tag_q, commit_tag_d;
  logic [31:0]          commit_data_q, commit_data_d;
  logic [4:0]           commit_target_q, commit_target_d;
  logic                 rollback_q, rollback_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [TAG_WIDTH-1:0] next_tag_q, next_tag_d;

  logic                 retire, mispredict, do_dispatch, cdb_hit, commit_wr;
  logic [IDX_W-1:0]     cdb_idx;

  assign dec_full_out = (count_q == FULL_CNT);

  // Next-state of the queue: retire decision, CDB capture, allocation, registered outputs.
  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    has_rd_d     = has_rd_q;
    is_branch_d  = is_branch_q;
    pred_taken_d = pred_taken_q;
    taken_d      = taken_q;
    rd_d         = rd_q;
    data_d       = data_q;
    alt_pc_d     = alt_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    // Retirement looks only at latched state, so a CDB write to the head commits one edge later.
    retire      = busy_q[head_q] & ready_q[head_q];
    mispredict  = retire & is_branch_q[head_q] & (taken_q[head_q] != pred_taken_q[head_q]);
    commit_wr   = retire & ~is_branch_q[head_q] & has_rd_q[head_q] & (rd_q[head_q] != 5'd0);
    do_dispatch = dec_valid_in & ~dec_full_out & ~mispredict;
    cdb_idx     = tag_idx(cdb_tag_in);
    cdb_hit     = cdb_valid_in & tag_valid(cdb_tag_in) & busy_q[cdb_idx];

    if (mispredict) begin
      // Flush everything; same-edge dispatch and CDB are discarded.
      busy_d  = {ROB_SIZE{1'b0}};
      ready_d = {ROB_SIZE{1'b0}};
      head_d  = {IDX_W{1'b0}};
      tail_d  = {IDX_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (cdb_hit) begin
        ready_d[cdb_idx] = 1'b1;
        data_d[cdb_idx]  = cdb_data_in;
        taken_d[cdb_idx] = cdb_taken_in;
      end else begin
        ready_d = ready_d;
      end
      if (retire) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + IDX_ONE;
      end else begin
        head_d = head_q;
      end
      if (do_dispatch) begin
        busy_d[tail_q]       = 1'b1;
        ready_d[tail_q]      = 1'b0;
        has_rd_d[tail_q]     = dec_has_rd_in;
        rd_d[tail_q]         = dec_rd_in;
        is_branch_d[tail_q]  = dec_is_branch_in;
        pred_taken_d[tail_q] = dec_pred_taken_in;
        taken_d[tail_q]      = 1'b0;
        alt_pc_d[tail_q]     = dec_alt_pc_in;
        tail_d               = tail_q + IDX_ONE;
      end else begin
        tail_d = tail_q;
      end
      case ({do_dispatch, retire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    commit_signal_d = commit_wr;
    commit_tag_d    = commit_wr ? (TAG_WIDTH'(head_q) + TAG_ONE) : TAG_NULL;
    commit_data_d   = commit_wr ? data_q[head_q] : 32'h0;
    commit_target_d = commit_wr ? rd_q[head_q] : 5'd0;
    rollback_d      = mispredict;
    redirect_pc_d   = mispredict ? alt_pc_q[head_q] : 32'h0;
    next_tag_d      = TAG_WIDTH'(tail_d) + TAG_ONE;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q          <= {ROB_SIZE{1'b0}};
      ready_q         <= {ROB_SIZE{1'b0}};
      has_rd_q        <= {ROB_SIZE{1'b0}};
      is_branch_q     <= {ROB_SIZE{1'b0}};
      pred_taken_q    <= {ROB_SIZE{1'b0}};
      taken_q         <= {ROB_SIZE{1'b0}};
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]     <= 5'd0;
        data_q[i]   <= 32'h0;
        alt_pc_q[i] <= 32'h0;
      end
      head_q          <= {IDX_W{1'b0}};
      tail_q          <= {IDX_W{1'b0}};
      count_q         <= {CNT_W{1'b0}};
      commit_signal_q <= 1'b0;
      commit_tag_q    <= TAG_NULL;
      commit_data_q   <= 32'h0;
      commit_target_q <= 5'd0;
      rollback_q      <= 1'b0;
      redirect_pc_q   <= 32'h0;
      next_tag_q      <= TAG_ONE;
    end else begin
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      has_rd_q        <= has_rd_d;
      is_branch_q     <= is_branch_d;
      pred_taken_q    <= pred_taken_d;
      taken_q         <= taken_d;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]     <= rd_d[i];
        data_q[i]   <= data_d[i];
        alt_pc_q[i] <= alt_pc_d[i];
      end
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_signal_q <= commit_signal_d;
      commit_tag_q    <= commit_tag_d;
      commit_data_q   <= commit_data_d;
      commit_target_q <= commit_target_d;
      rollback_q      <= rollback_d;
      redirect_pc_q   <= redirect_pc_d;
      next_tag_q      <= next_tag_d;
    end
  end

  // Operand queries against latched entries, optionally bypassing the live CDB.
  always_comb begin
    dec_Qj_ready_out = 1'b0;
    dec_Vj_out       = 32'h0;
    dec_Qk_ready_out = 1'b0;
    dec_Vk_out       = 32'h0;
    if (tag_valid(dec_Qj_in) && busy_q[tag_idx(dec_Qj_in)] && ready_q[tag_idx(dec_Qj_in)]) begin
      dec_Qj_ready_out = 1'b1;
      dec_Vj_out       = data_q[tag_idx(dec_Qj_in)];
    end else begin
      dec_Qj_ready_out = 1'b0;
    end
    if (tag_valid(dec_Qk_in) && busy_q[tag_idx(dec_Qk_in)] && ready_q[tag_idx(dec_Qk_in)]) begin
      dec_Qk_ready_out = 1'b1;
      dec_Vk_out       = data_q[tag_idx(dec_Qk_in)];
    end else begin
      dec_Qk_ready_out = 1'b0;
    end
`ifdef ROB_QUERY_FWD_EN
    if (cdb_valid_in && (dec_Qj_in != TAG_NULL) && (cdb_tag_in == dec_Qj_in)) begin
      dec_Qj_ready_out = 1'b1;
      dec_Vj_out       = cdb_data_in;
    end else begin
      dec_Vj_out = dec_Vj_out;
    end
    if (cdb_valid_in && (dec_Qk_in != TAG_NULL) && (cdb_tag_in == dec_Qk_in)) begin
      dec_Qk_ready_out = 1'b1;
      dec_Vk_out       = cdb_data_in;
    end else begin
      dec_Vk_out = dec_Vk_out;
    end
`endif
  end

  assign dec_next_tag_out      = next_tag_q;
  assign rob_commit_signal_out = commit_signal_q;
  assign rob_commit_tag_out    = commit_tag_q;
  assign rob_commit_data_out   = commit_data_q;
  assign rob_commit_target_out = commit_target_q;
  assign rob_rollback_out      = rollback_q;
  assign rob_redirect_pc_out   = redirect_pc_q;

endmodule
